// File: rtl/branch_predictor.sv
// Dynamic branch predictor for the fetch stage.
// A direct-mapped BTB: each entry holds a valid bit, a tag, a 32-bit target
// and a 2-bit saturating counter. Lookup is combinational on the IF PC, and
// training happens from the resolved beq/bne outcome at the MEM stage.
// Optional resolved-branch / misprediction counters are built only when the
// macro BRANCH_PREDICTOR_STATS_EN is defined. Otherwise the stat outputs are
// tied to zero.
module branch_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IFpc,
    output logic        PRtaken,
    output logic [31:0] PRtarget,
    input  logic        upd_en,
    input  logic        MMbranch,
    input  logic [31:0] MMpc,
    input  logic [31:0] MMtarget,
    input  logic        MMtaken,
    input  logic        MMprtaken,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDXW;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    logic            valid_q  [ENTRIES];
    logic [TAGW-1:0] tag_q    [ENTRIES];
    logic [31:0]     target_q [ENTRIES];
    cnt_e            cnt_q    [ENTRIES];

    logic [IDXW-1:0] lookupIdx;
    logic [TAGW-1:0] lookupTag;
    logic            lookupHit;

    logic            updEn;
    logic [IDXW-1:0] updIdx;
    logic [TAGW-1:0] updTag;
    logic            updHit;
    cnt_e            cnt_d;

    // The low PC bits are word-alignment bits and never take part in indexing.
    logic unusedPcBits;
    assign unusedPcBits = ^{IFpc[1:0], MMpc[1:0], MMprtaken};

    // Fetch-side lookup; it reads the stored state only, so a same-cycle write
    // to this index is not visible until the next cycle.
    always_comb begin
        lookupIdx = IFpc[IDXW+1:2];
        lookupTag = IFpc[31:IDXW+2];
        lookupHit = valid_q[lookupIdx] && (tag_q[lookupIdx] == lookupTag);
        PRtaken   = lookupHit && cnt_q[lookupIdx][1];
        PRtarget  = PRtaken ? target_q[lookupIdx] : 32'd0;
    end

    // Next counter value for the entry the MEM-stage branch maps to.
    always_comb begin
        updEn  = upd_en && MMbranch;
        updIdx = MMpc[IDXW+1:2];
        updTag = MMpc[31:IDXW+2];
        updHit = valid_q[updIdx] && (tag_q[updIdx] == updTag);
        cnt_d  = cnt_q[updIdx];
        if (!updHit) begin
            cnt_d = MMtaken ? WT : WNT;
        end else if (MMtaken) begin
            case (cnt_q[updIdx])
                SNT:     cnt_d = WNT;
                WNT:     cnt_d = WT;
                default: cnt_d = ST;
            endcase
        end else begin
            case (cnt_q[updIdx])
                ST:      cnt_d = WT;
                WT:      cnt_d = WNT;
                default: cnt_d = SNT;
            endcase
        end
    end

    // BTB storage: cleared by reset, one entry written per training event.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                cnt_q[i]    <= WNT;
            end
        end else if (updEn) begin
            valid_q[updIdx]  <= 1'b1;
            tag_q[updIdx]    <= updTag;
            target_q[updIdx] <= MMtarget;
            cnt_q[updIdx]    <= cnt_d;
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] statBranches_q;
    logic [31:0] statMispred_q;

    // Count resolved branches and those whose original prediction was wrong.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            statBranches_q <= 32'd0;
            statMispred_q  <= 32'd0;
        end else if (updEn) begin
            statBranches_q <= statBranches_q + 32'd1;
            if (MMtaken != MMprtaken) begin
                statMispred_q <= statMispred_q + 32'd1;
            end
        end
    end

    assign stat_branches = statBranches_q;
    assign stat_mispred  = statMispred_q;
`else
    assign stat_branches = 32'd0;
    assign stat_mispred  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor (ENTRIES = 16).
// Expected statistics depend on whether BRANCH_PREDICTOR_STATS_EN is defined.
module tb_branch_predictor;

`ifdef BRANCH_PREDICTOR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        CLK;
    logic        RST;
    logic [31:0] IFpc;
    logic        PRtaken;
    logic [31:0] PRtarget;
    logic        upd_en;
    logic        MMbranch;
    logic [31:0] MMpc;
    logic [31:0] MMtarget;
    logic        MMtaken;
    logic        MMprtaken;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;

    int testsRun = 0;
    int testsFailed = 0;

    branch_predictor #(.ENTRIES(16)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .IFpc          (IFpc),
        .PRtaken       (PRtaken),
        .PRtarget      (PRtarget),
        .upd_en        (upd_en),
        .MMbranch      (MMbranch),
        .MMpc          (MMpc),
        .MMtarget      (MMtarget),
        .MMtaken       (MMtaken),
        .MMprtaken     (MMprtaken),
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
    );

    // 10-time-unit clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", name, observed, expected);
        end
    endtask

    task automatic checkStats(input string name, input int branches, input int mispred);
        checkOutput({name, "_branches"}, stat_branches, STATS ? 32'(branches) : 32'd0);
        checkOutput({name, "_mispred"}, stat_mispred, STATS ? 32'(mispred) : 32'd0);
    endtask

    // Presents one MEM-stage branch for a single clock edge, then retires it.
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] tgt,
                                 input logic taken, input logic prtaken);
        upd_en    = 1'b1;
        MMbranch  = 1'b1;
        MMpc      = pc;
        MMtarget  = tgt;
        MMtaken   = taken;
        MMprtaken = prtaken;
        @(posedge CLK);
        #1;
        upd_en   = 1'b0;
        MMbranch = 1'b0;
    endtask

    task automatic lookup(input string name, input logic [31:0] pc,
                          input logic expTaken, input logic [31:0] expTarget);
        IFpc = pc;
        #1;
        checkOutput({name, "_taken"}, {31'd0, PRtaken}, {31'd0, expTaken});
        checkOutput({name, "_target"}, PRtarget, expTarget);
    endtask

    initial begin
        RST = 1'b1;
        IFpc = 32'h40;
        upd_en = 1'b0;
        MMbranch = 1'b0;
        MMpc = 32'd0;
        MMtarget = 32'd0;
        MMtaken = 1'b0;
        MMprtaken = 1'b0;

        // Reset state.
        #12;
        lookup("rst", 32'h40, 1'b0, 32'd0);
        checkStats("rst", 0, 0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Allocate taken -> WT, predicted taken.
        applyStimulus(32'h40, 32'h80, 1'b1, 1'b1);
        lookup("alloc", 32'h40, 1'b1, 32'h80);

        // Hysteresis: WT -> WNT -> SNT -> WNT -> WT.
        applyStimulus(32'h40, 32'h80, 1'b0, 1'b1);
        lookup("nt1", 32'h40, 1'b0, 32'd0);
        applyStimulus(32'h40, 32'h80, 1'b0, 1'b0);
        lookup("nt2", 32'h40, 1'b0, 32'd0);
        applyStimulus(32'h40, 32'h80, 1'b1, 1'b1);
        lookup("t1", 32'h40, 1'b0, 32'd0);
        applyStimulus(32'h40, 32'h90, 1'b1, 1'b0);
        lookup("t2", 32'h40, 1'b1, 32'h90);
        checkStats("five", 5, 2);

        // Aliasing: 0x440 shares index 0 with 0x40 but has another tag.
        applyStimulus(32'h440, 32'h500, 1'b0, 1'b0);
        lookup("alias_old", 32'h40, 1'b0, 32'd0);
        lookup("alias_new", 32'h440, 1'b0, 32'd0);
        applyStimulus(32'h440, 32'h504, 1'b1, 1'b1);
        lookup("alias_wnt", 32'h440, 1'b1, 32'h504);
        checkStats("alias", 7, 2);

        // Stall: branch held for 3 cycles with upd_en low trains nothing.
        IFpc = 32'h108;
        upd_en = 1'b0;
        MMbranch = 1'b1;
        MMpc = 32'h108;
        MMtarget = 32'h200;
        MMtaken = 1'b1;
        MMprtaken = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        lookup("stall", 32'h108, 1'b0, 32'd0);
        checkStats("stall", 7, 2);
        applyStimulus(32'h108, 32'h200, 1'b1, 1'b1);
        lookup("stall_once", 32'h108, 1'b1, 32'h200);
        checkStats("stall_once", 8, 2);

        // Same-cycle lookup of the index being written returns old state.
        upd_en = 1'b1;
        MMbranch = 1'b1;
        MMpc = 32'h108;
        MMtarget = 32'h204;
        MMtaken = 1'b0;
        MMprtaken = 1'b1;
        lookup("bypass_old", 32'h108, 1'b1, 32'h200);
        @(posedge CLK);
        #1;
        upd_en = 1'b0;
        MMbranch = 1'b0;
        lookup("bypass_new", 32'h108, 1'b0, 32'd0);
        checkStats("bypass", 9, 3);

        // Mid-cycle asynchronous reset while an update is pending.
        lookup("pre_rst", 32'h440, 1'b1, 32'h504);
        @(posedge CLK);
        #2;
        upd_en = 1'b1;
        MMbranch = 1'b1;
        MMpc = 32'h440;
        MMtaken = 1'b1;
        RST = 1'b1;
        #1;
        checkOutput("async_rst_taken", {31'd0, PRtaken}, 32'd0);
        checkOutput("async_rst_target", PRtarget, 32'd0);
        checkStats("async_rst", 0, 0);
        upd_en = 1'b0;
        MMbranch = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        lookup("post_rst_a", 32'h440, 1'b0, 32'd0);
        lookup("post_rst_b", 32'h108, 1'b0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
